// File: rtl/cache_pkg.sv
// Shared definitions for the two-way cache: FSM state encoding, default geometry
// and address-field slicing used by both the controller and the array.
package cache_pkg;

   localparam int OFFSET_W_DEF = 3;
   localparam int INDEX_W_DEF  = 6;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE      = 3'd0;
   localparam state_t S_COMPARE   = 3'd1;
   localparam state_t S_PROBE     = 3'd2;
   localparam state_t S_WRITEBACK = 3'd3;
   localparam state_t S_ALLOCATE  = 3'd4;
   localparam state_t S_INSTALL   = 3'd5;

   // Field extractors return right-justified 32-bit values; callers narrow to width.
   function automatic logic [31:0] addr_word(input logic [31:0] addr, input int ow);
      return (addr >> 2) & ((32'd1 << ow) - 32'd1);
   endfunction

   function automatic logic [31:0] addr_index(input logic [31:0] addr, input int ow, input int iw);
      return (addr >> (ow + 2)) & ((32'd1 << iw) - 32'd1);
   endfunction

   function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int ow, input int iw);
      return addr >> (ow + iw + 2);
   endfunction

endpackage

// File: rtl/cache_perf_cnt.sv
// 32-bit performance counter that increments on inc and sticks at all-ones.
module cache_perf_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [31:0] count
);

   logic [31:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else if (inc && (cnt_q != 32'hFFFF_FFFF))
         cnt_q <= cnt_q + 32'd1;
   end

   assign count = cnt_q;

endmodule

// File: rtl/cache_ctrl_2way.sv
// Miss-handling controller for a two-way set-associative cache: hit/compare path,
// victim probe, dirty write-back, block refill, install and replay.
module cache_ctrl_2way
   import cache_pkg::*;
#(
   parameter int OFFSET_WIDTH = OFFSET_W_DEF,
   parameter int INDEX_WIDTH  = INDEX_W_DEF,
   parameter int TAG_WIDTH    = 30 - OFFSET_WIDTH - INDEX_WIDTH,
   parameter int BLOCK_BITS   = 32 << OFFSET_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cpu_req,
   input  logic                    cpu_we,
   input  logic [31:0]             cpu_addr,
   input  logic [3:0]              cpu_byte_en,
   input  logic [31:0]             cpu_wdata,
   output logic [31:0]             cpu_rdata,
   output logic                    cpu_ready,
   output logic                    cpu_busy,
   output logic                    cache_enable,
   output logic                    cache_cmp,
   output logic                    cache_write,
   output logic                    cache_valid_in,
   output logic [3:0]              cache_byte_w_en,
   output logic [TAG_WIDTH-1:0]    cache_tag_in,
   output logic [INDEX_WIDTH-1:0]  cache_index,
   output logic [OFFSET_WIDTH-1:0] cache_word_sel,
   output logic [31:0]             cache_data_in,
   output logic [BLOCK_BITS-1:0]   cache_block_in,
   input  logic                    cache_hit,
   input  logic                    cache_dirty,
   input  logic                    cache_valid,
   input  logic [TAG_WIDTH-1:0]    cache_tag_out,
   input  logic [31:0]             cache_data_out,
   input  logic [BLOCK_BITS-1:0]   cache_data_wb,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [31:0]             mem_addr,
   output logic [BLOCK_BITS-1:0]   mem_wdata,
   input  logic [BLOCK_BITS-1:0]   mem_rdata,
   input  logic                    mem_ack,
   output logic [31:0]             hit_cnt,
   output logic [31:0]             miss_cnt,
   output logic [31:0]             wb_cnt
);

   localparam int BLK_LSB = OFFSET_WIDTH + 2;

   state_t                  state, state_nxt;
   logic                    req_we;
   logic [31:0]             req_addr;
   logic [3:0]              req_be;
   logic [31:0]             req_wdata;
   logic [TAG_WIDTH-1:0]    vic_tag;
   logic [BLOCK_BITS-1:0]   vic_block;
   logic [BLOCK_BITS-1:0]   refill_buf;
   logic                    replay;
   logic [TAG_WIDTH-1:0]    req_tag;
   logic [INDEX_WIDTH-1:0]  req_index;
   logic                    hit_inc, miss_inc, wb_inc;

   assign req_tag        = TAG_WIDTH'(addr_tag(req_addr, OFFSET_WIDTH, INDEX_WIDTH));
   assign req_index      = INDEX_WIDTH'(addr_index(req_addr, OFFSET_WIDTH, INDEX_WIDTH));
   assign cache_tag_in   = req_tag;
   assign cache_index    = req_index;
   assign cache_word_sel = OFFSET_WIDTH'(addr_word(req_addr, OFFSET_WIDTH));
   assign cache_data_in  = req_wdata;
   assign cache_block_in = refill_buf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (cpu_req) state_nxt = S_COMPARE;
         S_COMPARE:   state_nxt = cache_hit ? S_IDLE : S_PROBE;
         S_PROBE:     state_nxt = (cache_valid && cache_dirty) ? S_WRITEBACK : S_ALLOCATE;
         S_WRITEBACK: if (mem_ack) state_nxt = S_ALLOCATE;
         S_ALLOCATE:  if (mem_ack) state_nxt = S_INSTALL;
         S_INSTALL:   state_nxt = S_COMPARE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      cpu_rdata       = '0;
      cpu_ready       = 1'b0;
      cpu_busy        = (state != S_IDLE);
      cache_enable    = 1'b0;
      cache_cmp       = 1'b0;
      cache_write     = 1'b0;
      cache_valid_in  = 1'b0;
      cache_byte_w_en = '0;
      mem_req         = 1'b0;
      mem_we          = 1'b0;
      mem_addr        = '0;
      mem_wdata       = '0;
      case (state)
         S_COMPARE: begin
            cache_enable    = 1'b1;
            cache_cmp       = 1'b1;
            cache_write     = req_we;
            cache_byte_w_en = req_be;
            if (cache_hit) begin
               cpu_ready = 1'b1;
               cpu_rdata = cache_data_out;
            end
         end
         S_PROBE: cache_enable = 1'b1;
         S_WRITEBACK: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {vic_tag, req_index, {BLK_LSB{1'b0}}};
            mem_wdata = vic_block;
         end
         S_ALLOCATE: begin
            mem_req  = 1'b1;
            mem_addr = {req_tag, req_index, {BLK_LSB{1'b0}}};
         end
         // Whole-block install; the line goes in clean, the replay applies any store.
         S_INSTALL: begin
            cache_enable    = 1'b1;
            cache_write     = 1'b1;
            cache_valid_in  = 1'b1;
            cache_byte_w_en = 4'hF;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_we     <= 1'b0;
         req_addr   <= '0;
         req_be     <= '0;
         req_wdata  <= '0;
         vic_tag    <= '0;
         vic_block  <= '0;
         refill_buf <= '0;
         replay     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               replay <= 1'b0;
               if (cpu_req) begin
                  req_we    <= cpu_we;
                  req_addr  <= cpu_addr;
                  req_be    <= cpu_byte_en;
                  req_wdata <= cpu_wdata;
               end
            end
            S_PROBE: if (cache_valid && cache_dirty) begin
               vic_tag   <= cache_tag_out;
               vic_block <= cache_data_wb;
            end
            S_ALLOCATE: if (mem_ack) refill_buf <= mem_rdata;
            S_INSTALL:  replay <= 1'b1;
            default: ;
         endcase
      end
   end

   // The post-install replay hit belongs to an access already counted as a miss.
   assign hit_inc  = (state == S_COMPARE) && cache_hit && !replay;
   assign miss_inc = (state == S_COMPARE) && !cache_hit;
   assign wb_inc   = (state == S_WRITEBACK) && mem_ack;

   cache_perf_cnt u_hit_cnt  (.clk(clk), .rst(rst), .inc(hit_inc),  .count(hit_cnt));
   cache_perf_cnt u_miss_cnt (.clk(clk), .rst(rst), .inc(miss_inc), .count(miss_cnt));
   cache_perf_cnt u_wb_cnt   (.clk(clk), .rst(rst), .inc(wb_inc),   .count(wb_cnt));

endmodule
